// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between P0 (fetch) and P1 (data).
// Each access takes exactly three cycles: IDLE (decide), ACCESS (strobe), RESP (rvalid).
module ram_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_ou
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // One extra bit so DEPTH = 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    state_t                  r_state;
    logic                    r_last_gnt;   // 0 = P0, 1 = P1
    logic                    r_winner;
    logic                    r_we;
    logic                    r_oor;
    logic [1:0]              r_gnt;
    logic [1:0]              r_rvalid;
    logic [1:0]              r_err;
    logic [1:0][DATA_W-1:0]  r_rdata;
    logic                    r_ram_read;
    logic                    r_ram_write;
    logic [ADDR_W-1:0]       r_ram_addr;
    logic [DATA_W-1:0]       r_ram_in;

    logic [1:0]              w_req;
    logic [1:0]              w_we;
    logic [1:0][ADDR_W-1:0]  w_addr;
    logic [1:0][DATA_W-1:0]  w_wdata;
    logic                    w_pick;
    logic                    w_sel_we;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [DATA_W-1:0]       w_sel_wdata;
    logic                    w_sel_oor;

    assign w_req   = {p1_req,   p0_req};
    assign w_we    = {p1_we,    p0_we};
    assign w_addr  = {p1_addr,  p0_addr};
    assign w_wdata = {p1_wdata, p0_wdata};

    // P1 wins when it is the only requester, or on a tie when P0 was served last.
    assign w_pick      = w_req[1] & (~w_req[0] | ~r_last_gnt);
    assign w_sel_we    = w_we[w_pick];
    assign w_sel_addr  = w_addr[w_pick];
    assign w_sel_wdata = w_wdata[w_pick];
    assign w_sel_oor   = ({1'b0, w_sel_addr} >= LP_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= 1'b1;
            r_winner    <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_in    <= '0;
        end else begin
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_err       <= '0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_winner        <= w_pick;
                        r_last_gnt      <= w_pick;
                        r_we            <= w_sel_we;
                        r_oor           <= w_sel_oor;
                        r_ram_addr      <= w_sel_addr;
                        r_ram_in        <= w_sel_wdata;
                        r_gnt[w_pick]   <= 1'b1;
                        r_ram_read      <= ~w_sel_oor & ~w_sel_we;
                        r_ram_write     <= ~w_sel_oor &  w_sel_we;
                        r_state         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Strobes drop here while addr/data stay held through RESP.
                    r_rvalid[r_winner] <= 1'b1;
                    r_err[r_winner]    <= r_oor;
                    if (!r_we) begin
                        r_rdata[r_winner] <= r_oor ? '0 : ram_ou;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign p0_gnt    = r_gnt[0];
    assign p1_gnt    = r_gnt[1];
    assign p0_rvalid = r_rvalid[0];
    assign p1_rvalid = r_rvalid[1];
    assign p0_err    = r_err[0];
    assign p1_err    = r_err[1];
    assign p0_rdata  = r_rdata[0];
    assign p1_rdata  = r_rdata[1];
    assign ram_read  = r_ram_read;
    assign ram_write = r_ram_write;
    assign ram_addr  = r_ram_addr;
    assign ram_in    = r_ram_in;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares them and checks strobe/handshake invariants.
module tb_ram_port_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          ram_read, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_in, ram_ou;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_in(ram_in), .ram_ou(ram_ou)
    );

    // RAM model: combinational read, write on the clock while the strobe is high.
    logic [DW-1:0] mem [DEPTH];
    assign ram_ou = mem[ram_addr[7:0]];
    always @(posedge clk) if (ram_write) mem[ram_addr[7:0]] <= ram_in;

    typedef struct { int port; logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] din; } gnt_t;
    typedef struct { int port; logic err; logic [DW-1:0] rdata; } rsp_t;
    gnt_t gq[$];
    rsp_t rq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    int            gnt_cyc [2];
    logic          prev_strobe = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_in;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = 1'b0;
        end else begin
            if (p0_gnt || p1_gnt) begin
                check("gnt_exclusive", {31'd0, p0_gnt & p1_gnt}, 32'd0);
                if (gq.size() == 0) begin
                    check("unexpected_gnt", 32'd1, 32'd0);
                end else begin
                    gnt_t g;
                    int   p;
                    g = gq.pop_front();
                    p = p1_gnt ? 1 : 0;
                    check("gnt_port", p, g.port);
                    check("ram_read", {31'd0, ram_read}, {31'd0, g.rd});
                    check("ram_write", {31'd0, ram_write}, {31'd0, g.wr});
                    check("ram_addr", {16'd0, ram_addr}, {16'd0, g.addr});
                    if (g.wr) check("ram_in", {16'd0, ram_in}, {16'd0, g.din});
                    gnt_cyc[p] = cyc;
                    $display("gnt  P%0d rd=%0b wr=%0b addr=%h in=%h cycle %0d", p, ram_read, ram_write, ram_addr, ram_in, cyc);
                end
            end
            if (p0_rvalid || p1_rvalid) begin
                check("rvalid_exclusive", {31'd0, p0_rvalid & p1_rvalid}, 32'd0);
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    rsp_t r;
                    int   p;
                    r = rq.pop_front();
                    p = p1_rvalid ? 1 : 0;
                    check("rvalid_port", p, r.port);
                    check("rvalid_latency", cyc - gnt_cyc[p], 1);
                    check("err", {31'd0, p ? p1_err : p0_err}, {31'd0, r.err});
                    check("rdata", {16'd0, p ? p1_rdata : p0_rdata}, {16'd0, r.rdata});
                    $display("rsp  P%0d err=%0b rdata=%h cycle %0d", p, p ? p1_err : p0_err, p ? p1_rdata : p0_rdata, cyc);
                end
            end
            if (ram_read || ram_write)
                check("strobe_exclusive", {31'd0, ram_read & ram_write}, 32'd0);
            if (prev_strobe) begin
                check("addr_stable", {16'd0, ram_addr}, {16'd0, prev_addr});
                check("in_stable", {16'd0, ram_in}, {16'd0, prev_in});
            end
            prev_strobe = ram_read | ram_write;
            prev_addr   = ram_addr;
            prev_in     = ram_in;
        end
    end

    task automatic set_port(input int port, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end
    endtask

    task automatic push_exp(input int port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic err, input logic [DW-1:0] rd,
                            input logic with_rsp);
        gnt_t g;
        rsp_t r;
        g.port = port; g.rd = ~err & ~we; g.wr = ~err & we; g.addr = addr; g.din = wd;
        gq.push_back(g);
        if (with_rsp) begin
            r.port = port; r.err = err; r.rdata = rd;
            rq.push_back(r);
        end
    endtask

    // Wait (bounded) at negedges for the given port's grant; returns cycles waited.
    task automatic wait_gnt(input int port, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? p1_gnt : p0_gnt) && n < 20);
        if (!(port ? p1_gnt : p0_gnt)) check("gnt_timeout", 32'd1, 32'd0);
    endtask

    // Single access from an idle arbiter; expected values supplied by the caller.
    task automatic issue(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic exp_err, input logic [DW-1:0] exp_rd);
        int n;
        push_exp(port, we, addr, wd, exp_err, exp_rd, 1'b1);
        set_port(port, 1'b1, we, addr, wd);
        wait_gnt(port, n);
        check("gnt_latency", n, 1);
        set_port(port, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int gcount;
        int gc [4];
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check("reset_handshake", {26'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err}, 32'd0);
        check("reset_strobes", {30'd0, ram_read, ram_write}, 32'd0);
        check("reset_rdata", {p0_rdata, p1_rdata}, 32'd0);
        check("reset_ram_bus", {ram_addr, ram_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read-back, range edges, out-of-range handling
        issue(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
        issue(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);
        issue(1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0000);
        issue(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA5A5);
        issue(0, 1'b1, 16'h00FF, 16'h1234, 1'b0, 16'hA5A5);
        issue(1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 16'h1234);
        issue(0, 1'b1, 16'hFFFF, 16'h5555, 1'b1, 16'hA5A5);
        issue(1, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'hA5A4);

        // Both ports requesting continuously right after reset: P0,P1,P0,P1
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_exp(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1'b1);
            push_exp(1, 1'b1, 16'h0030, 16'h2222, 1'b0, 16'h0000, 1'b1);
        end
        set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        set_port(1, 1'b1, 1'b1, 16'h0030, 16'h2222);
        gcount = 0;
        for (int t = 0; t < 40 && gcount < 4; t++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) begin
                gc[gcount] = cyc;
                gcount++;
            end
        end
        check("rr_grant_count", gcount, 4);
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        for (int k = 1; k < 4; k++) check("rr_grant_spacing", gc[k] - gc[k-1], 3);
        repeat (3) @(negedge clk);

        // Reset in the middle of a write access
        push_exp(0, 1'b1, 16'h0040, 16'h7777, 1'b0, 16'h0000, 1'b0);
        set_port(0, 1'b1, 1'b1, 16'h0040, 16'h7777);
        wait_gnt(0, n);
        #2;
        rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        #1;
        check("reset_mid_write_strobe", {31'd0, ram_write}, 32'd0);
        check("reset_mid_write_gnt", {31'd0, p0_gnt}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("reset_no_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        end
        rst_n = 1'b1;
        push_exp(0, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h2222, 1'b1);
        push_exp(1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 16'h1234, 1'b1);
        set_port(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        set_port(1, 1'b1, 1'b0, 16'h00FF, 16'h0000);
        wait_gnt(0, n);
        check("post_reset_p0_first", n, 1);
        set_port(0, 1'b0, 1'b0, '0, '0);
        wait_gnt(1, n);
        check("pending_p1_wait", n, 3);
        set_port(1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);

        check("gnt_queue_drained", gq.size(), 0);
        check("rsp_queue_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
